mmio_io_hub: RTL and testbench

//  Parametrised memory-mapped I/O hub for the minisys CPU. It replaces the fixed single-bank
//  LED / 16-bit switch path. A request/response handshake sits between the core's load/store

---
 rtl/mmio_io_hub.sv | 180 ++++++++++++++++++
 tb/tb_mmio_io_hub.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: LED banks, debounced switch port and a 1-cycle request/response handshake.
// Optional switch-change interrupt flag at offset 0x74 is enabled by defining SW_EDGE_IRQ_EN.
module mmio_io_hub #(
    parameter int DATA_W      = 32,
    parameter int SW_W        = 16,
    parameter int LED_CH      = 2,
    parameter int LED_W       = 16,
    parameter logic [DATA_W-11:0] IO_BASE = 22'h3FFFFF,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [DATA_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    req_ready,
    output logic                    resp_valid,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic                    resp_err,
    input  logic [SW_W-1:0]         switches,
    output logic [LED_CH*LED_W-1:0] ledout,
    output logic                    sw_irq
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [SW_W-1:0]   r_sync [SYNC_STAGES];
    logic [SW_W-1:0]   r_cand;
    logic [SW_W-1:0]   r_deb;
    logic [CNT_W-1:0]  r_cnt;
    logic [LED_W-1:0]  r_led [LED_CH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_accept;
    logic [7:0]        w_offset;
    logic              w_is_io;
    logic              w_aligned;
    logic              w_sw_hit;
    logic              w_irq_hit;
    logic [LED_CH-1:0] w_led_sel;
    logic              w_led_hit;
    logic              w_err;
    logic [DATA_W-1:0] w_rdata;
    logic [SW_W-1:0]   w_sync;
    logic              w_match;
    logic              w_sw_change;
    logic              w_unused;

    assign w_unused = ^{req_addr[9:8], req_wdata};

    // ---------------- switch synchroniser and debounce ----------------
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= switches;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_match     = (w_sync == r_cand);
    assign w_sw_change = w_match && (r_cnt == CNT_MAX) && (r_cand != r_deb);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_cand <= '0;
            r_cnt  <= '0;
            r_deb  <= '0;
        end else if (!w_match) begin
            r_cand <= w_sync;
            r_cnt  <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_deb  <= r_cand;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // ---------------- handshake FSM ----------------
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign w_accept   = req_valid && req_ready;

    // ---------------- address decode ----------------
    assign w_offset  = req_addr[7:0];
    assign w_is_io   = (req_addr[DATA_W-1:10] == IO_BASE);
    assign w_aligned = (req_addr[1:0] == 2'b00);
    assign w_sw_hit  = (w_offset == 8'h70);
`ifdef SW_EDGE_IRQ_EN
    assign w_irq_hit = (w_offset == 8'h74);
`else
    assign w_irq_hit = 1'b0;
`endif

    // Switch/irq offsets take priority over LED banks that would overlap them when LED_CH > 4.
    genvar gi;
    generate
        for (gi = 0; gi < LED_CH; gi++) begin : g_led_dec
            assign w_led_sel[gi] = (w_offset == 8'(8'h60 + 4*gi)) && !w_sw_hit && !w_irq_hit;
            assign ledout[gi*LED_W +: LED_W] = r_led[gi];
        end
    endgenerate

    assign w_led_hit = |w_led_sel;
    assign w_err = !w_is_io || !w_aligned || !(w_sw_hit || w_irq_hit || w_led_hit)
                 || (req_write && (w_sw_hit || w_irq_hit));

`ifdef SW_EDGE_IRQ_EN
    logic r_flag;
    logic w_irq_clear;

    assign w_irq_clear = w_accept && !req_write && !w_err && w_irq_hit;

    // A coincident switch change wins over the clearing load.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst)             r_flag <= 1'b0;
        else if (w_sw_change) r_flag <= 1'b1;
        else if (w_irq_clear) r_flag <= 1'b0;
    end

    assign sw_irq = r_flag;
`else
    assign sw_irq = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        if (!w_err && !req_write) begin
            if (w_sw_hit) w_rdata[SW_W-1:0] = r_deb;
`ifdef SW_EDGE_IRQ_EN
            if (w_irq_hit) w_rdata[0] = r_flag;
`endif
            for (int k = 0; k < LED_CH; k++) begin
                if (w_led_sel[k]) w_rdata[LED_W-1:0] = r_led[k];
            end
        end
    end

    // ---------------- response and LED registers ----------------
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            for (int k = 0; k < LED_CH; k++) r_led[k] <= '0;
        end else if (w_accept) begin
            r_rdata <= w_rdata;
            r_err   <= w_err;
            for (int k = 0; k < LED_CH; k++) begin
                if (req_write && !w_err && w_led_sel[k]) r_led[k] <= req_wdata[LED_W-1:0];
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Scoreboard bench for mmio_io_hub: stimulus pushes expected responses, a monitor pops and compares.
// Define SW_EDGE_IRQ_EN to also exercise the switch-change interrupt flag.
module tb_mmio_io_hub;

    logic        clock = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, sw_irq;
    logic [31:0] resp_rdata;
    logic [15:0] switches;
    logic [31:0] ledout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    mmio_io_hub dut (
        .clock      (clock),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .switches   (switches),
        .ledout     (ledout),
        .sw_irq     (sw_irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe is matched against the oldest expectation.
    always @(negedge clock) begin
        if (rst === 1'b1 && resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata=0x%08h err=%0b expected no response",
                         resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("resp %-16s rdata=0x%08h err=%0b (exp 0x%08h/%0b)",
                         e.name, resp_rdata, resp_err, e.rdata, e.err);
                check({e.name, "_rdata"}, resp_rdata, e.rdata);
                check({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    end

    // Called at a negedge with the hub idle; returns at a negedge with the hub idle again.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input string name);
        exp_t e;
        check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.name  = name;
        sb_q.push_back(e);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 32'hFFFFFC64;
        req_wdata = 32'hDEADBEEF;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        switches  = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_ledout", ledout, 32'd0);
        check("rst_sw_irq", {31'd0, sw_irq}, 32'd0);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);

        // Reset in the middle of a response drops it and clears the LEDs asynchronously.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'hFFFFFC60;
        req_wdata = 32'h00005555;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        check("midresp_led_commit", ledout, 32'h00005555);
        check("midresp_valid_hi", {31'd0, resp_valid}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("midresp_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("midresp_rst_ledout", ledout, 32'd0);
        check("midresp_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);

        // LED bank 0 store and load back.
        issue(1'b1, 32'hFFFFFC60, 32'h0000A5A5, 32'h0, 1'b0, "st_led0");
        check("led0_after_store", ledout, 32'h0000A5A5);
        issue(1'b0, 32'hFFFFFC60, 32'h0, 32'h0000A5A5, 1'b0, "ld_led0");

        // LED bank 1, and the first unmapped bank beyond LED_CH.
        issue(1'b1, 32'hFFFFFC64, 32'hFFFF1234, 32'h0, 1'b0, "st_led1");
        check("led1_after_store", ledout, 32'h1234A5A5);
        issue(1'b1, 32'hFFFFFC68, 32'h00007777, 32'h0, 1'b1, "st_led2_unmapped");
        check("ledout_after_err", ledout, 32'h1234A5A5);
        issue(1'b0, 32'hFFFFFC64, 32'h0, 32'h00001234, 1'b0, "ld_led1");

        // Error cases.
        issue(1'b0, 32'h00000010, 32'h0, 32'h0, 1'b1, "ld_non_io");
        issue(1'b0, 32'hFFFFF870, 32'h0, 32'h0, 1'b1, "ld_base_minus1");
        issue(1'b1, 32'hFFFFFC70, 32'h0000FFFF, 32'h0, 1'b1, "st_switches");
        issue(1'b1, 32'hFFFFFC62, 32'h0000BEEF, 32'h0, 1'b1, "st_misaligned");
        check("ledout_after_errs", ledout, 32'h1234A5A5);

        // Switch debounce: the new value appears only after the sync+debounce delay.
        switches = 16'h00F0;
        issue(1'b0, 32'hFFFFFC70, 32'h0, 32'h00000000, 1'b0, "ld_sw_immediate");
        repeat (12) @(negedge clock);
        issue(1'b0, 32'hFFFFFC70, 32'h0, 32'h00000000, 1'b0, "ld_sw_early");
        repeat (30) @(negedge clock);
        issue(1'b0, 32'hFFFFFC70, 32'h0, 32'h000000F0, 1'b0, "ld_sw_settled");
        switches = 16'h0000;
        repeat (5) @(negedge clock);
        switches = 16'h00F0;
        issue(1'b0, 32'hFFFFFC70, 32'h0, 32'h000000F0, 1'b0, "ld_sw_glitch");
        repeat (30) @(negedge clock);
        issue(1'b0, 32'hFFFFFC70, 32'h0, 32'h000000F0, 1'b0, "ld_sw_after_glitch");

`ifdef SW_EDGE_IRQ_EN
        check("irq_set_by_change", {31'd0, sw_irq}, 32'd1);
        issue(1'b0, 32'hFFFFFC74, 32'h0, 32'h00000001, 1'b0, "ld_irq_set");
        check("irq_cleared", {31'd0, sw_irq}, 32'd0);
        issue(1'b0, 32'hFFFFFC74, 32'h0, 32'h00000000, 1'b0, "ld_irq_clear");
        issue(1'b1, 32'hFFFFFC74, 32'h1, 32'h0, 1'b1, "st_irq");
        // The new value lands in sw_deb on the 19th edge after this negedge; accept there too.
        switches = 16'h00F1;
        repeat (18) @(negedge clock);
        issue(1'b0, 32'hFFFFFC74, 32'h0, 32'h00000000, 1'b0, "ld_irq_coincide");
        check("irq_set_wins", {31'd0, sw_irq}, 32'd1);
        issue(1'b0, 32'hFFFFFC70, 32'h0, 32'h000000F1, 1'b0, "ld_sw_f1");
`else
        check("irq_tied_low", {31'd0, sw_irq}, 32'd0);
        issue(1'b0, 32'hFFFFFC74, 32'h0, 32'h0, 1'b1, "ld_irq_unmapped");
`endif

        repeat (2) @(negedge clock);
        check("scoreboard_drain", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
